// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: IF/ID/EXE/MEM/WB/HLT sequencer with datapath control decode
// and a retired-instruction counter.
module multi_cycle_ctrl #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  output logic               PCWre,
  output logic               PCSrc,
  output logic               IRWre,
  output logic               RegWre,
  output logic               RegDst,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [2:0]         ALUOp,
  output logic               Halt,
  output logic [2:0]         State,
  output logic [COUNT_W-1:0] InsCount
);

  typedef enum logic [2:0] {
    StIf  = 3'b000,
    StId  = 3'b001,
    StExe = 3'b010,
    StMem = 3'b011,
    StWb  = 3'b100,
    StHlt = 3'b101
  } state_e;

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpBne  = 6'b110101;
  localparam logic [5:0] OpHalt = 6'b111111;

  state_e               r_state;
  state_e               w_state_next;
  logic [5:0]           r_op;
  logic [COUNT_W-1:0]   r_cnt;

  logic w_add, w_sub, w_addi, w_ori, w_sw, w_lw, w_beq, w_bne, w_halt, w_nop;
  logic w_pcwre, w_pcsrc, w_irwre, w_regwre, w_mrd, w_mwr, w_halt_o, w_dp;

  assign w_add  = (r_op == OpAdd);
  assign w_sub  = (r_op == OpSub);
  assign w_addi = (r_op == OpAddi);
  assign w_ori  = (r_op == OpOri);
  assign w_sw   = (r_op == OpSw);
  assign w_lw   = (r_op == OpLw);
  assign w_beq  = (r_op == OpBeq);
  assign w_bne  = (r_op == OpBne);
  assign w_halt = (r_op == OpHalt);
  assign w_nop  = ~(w_add | w_sub | w_addi | w_ori | w_sw | w_lw | w_beq | w_bne | w_halt);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= StIf;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIf) begin
        r_op <= Opcode;
      end
      if (w_pcwre) begin
        r_cnt <= r_cnt + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pcwre      = 1'b0;
    w_pcsrc      = 1'b0;
    w_irwre      = 1'b0;
    w_regwre     = 1'b0;
    w_mrd        = 1'b0;
    w_mwr        = 1'b0;
    w_halt_o     = 1'b0;
    w_dp         = 1'b0;
    case (r_state)
      StIf: begin
        w_irwre      = 1'b1;
        w_state_next = StId;
      end
      StId: begin
        w_dp = 1'b1;
        if (w_halt) begin
          w_state_next = StHlt;
        end else if (w_nop) begin
          w_state_next = StIf;
          w_pcwre      = 1'b1;
        end else begin
          w_state_next = StExe;
        end
      end
      StExe: begin
        w_dp = 1'b1;
        if (w_beq || w_bne) begin
          w_state_next = StIf;
          w_pcwre      = 1'b1;
          w_pcsrc      = (w_beq & Zero) | (w_bne & ~Zero);
        end else if (w_lw || w_sw) begin
          w_state_next = StMem;
        end else begin
          w_state_next = StWb;
        end
      end
      StMem: begin
        w_dp  = 1'b1;
        w_mrd = w_lw;
        w_mwr = w_sw;
        if (w_sw) begin
          w_state_next = StIf;
          w_pcwre      = 1'b1;
        end else begin
          w_state_next = StWb;
        end
      end
      StWb: begin
        w_dp         = 1'b1;
        w_regwre     = 1'b1;
        w_pcwre      = 1'b1;
        w_state_next = StIf;
      end
      StHlt: begin
        w_halt_o     = 1'b1;
        w_state_next = StHlt;
      end
      default: w_state_next = StIf;
    endcase
  end

  // Unknown opcodes decode to NOP, which drives no datapath controls at all.
  logic w_dec;
  assign w_dec = w_dp & ~w_nop & Reset;

  assign IRWre     = Reset & w_irwre;
  assign PCWre     = Reset & w_pcwre;
  assign PCSrc     = Reset & w_pcsrc;
  assign RegWre    = Reset & w_regwre;
  assign mRD       = Reset & w_mrd;
  assign mWR       = Reset & w_mwr;
  assign Halt      = Reset & w_halt_o;
  assign RegDst    = w_dec & (w_add | w_sub);
  assign ALUSrcB   = w_dec & (w_addi | w_ori | w_lw | w_sw);
  assign ExtSel    = w_dec & ~w_ori;
  assign DBDataSrc = w_dec & w_lw;
  assign ALUOp     = !w_dec                  ? 3'b000 :
                     (w_sub | w_beq | w_bne) ? 3'b001 :
                     w_ori                   ? 3'b011 : 3'b000;
  assign State     = r_state;
  assign InsCount  = r_cnt;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: instruction table with a per-cycle scoreboard,
// plus hand-written HALT, async reset and counter-wrap sequences.
module tb_multi_cycle_ctrl;

  localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010;
  localparam logic [2:0] S_MEM = 3'b011, S_WB = 3'b100, S_HLT = 3'b101;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_ORI = 6'b010010, OP_SW = 6'b110000, OP_LW = 6'b110001;
  localparam logic [5:0] OP_BEQ = 6'b110100, OP_BNE = 6'b110101, OP_HALT = 6'b111111;
  localparam logic [5:0] OP_NOP = 6'b101010;

  typedef struct {
    logic [5:0]      op;
    logic            zero;
    int              len;
    logic [4:0][2:0] path;  // path[0] is the first (IF) cycle
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [13:0] bits;
    logic        pcw;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset, Zero;
  logic [5:0]  Opcode;
  logic        PCWre, PCSrc, IRWre, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc, Halt;
  logic [2:0]  ALUOp, State;
  logic [15:0] InsCount;

  logic        Reset2;
  logic [5:0]  Opcode2;
  logic        Zero2;
  logic        PCWre2, PCSrc2, IRWre2, RegWre2, RegDst2, ALUSrcB2, ExtSel2, mRD2, mWR2;
  logic        DBDataSrc2, Halt2;
  logic [2:0]  ALUOp2, State2;
  logic [3:0]  InsCount2;

  logic [13:0] w_act;
  assign w_act = {IRWre, PCWre, PCSrc, RegWre, RegDst, ALUSrcB, ExtSel, mRD, mWR, DBDataSrc,
                  ALUOp, Halt};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = '0;
  vec_t        tbl[12];
  int          n_tbl = 0;
  exp_t        sb[$];

  always #5 CLK = ~CLK;

  multi_cycle_ctrl #(.COUNT_W(16)) u_dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
    .ALUOp(ALUOp), .Halt(Halt), .State(State), .InsCount(InsCount)
  );

  multi_cycle_ctrl #(.COUNT_W(4)) u_dut_w4 (
    .CLK(CLK), .Reset(Reset2), .Opcode(Opcode2), .Zero(Zero2),
    .PCWre(PCWre2), .PCSrc(PCSrc2), .IRWre(IRWre2), .RegWre(RegWre2), .RegDst(RegDst2),
    .ALUSrcB(ALUSrcB2), .ExtSel(ExtSel2), .mRD(mRD2), .mWR(mWR2), .DBDataSrc(DBDataSrc2),
    .ALUOp(ALUOp2), .Halt(Halt2), .State(State2), .InsCount(InsCount2)
  );

  // Expected {IRWre,PCWre,PCSrc,RegWre,RegDst,ALUSrcB,ExtSel,mRD,mWR,DBDataSrc,ALUOp,Halt}.
  function automatic logic [13:0] exp_ctrl(input logic [2:0] st, input logic [5:0] op,
                                           input logic z, input logic pcw);
    logic known, dp, pcs, asb, ext, rd, dbs;
    logic [2:0] aop;
    known = op inside {OP_ADD, OP_SUB, OP_ADDI, OP_ORI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_HALT};
    dp    = known && (st inside {S_ID, S_EXE, S_MEM, S_WB});
    pcs   = (st == S_EXE) && (((op == OP_BEQ) && z) || ((op == OP_BNE) && !z));
    asb   = dp && (op inside {OP_ADDI, OP_ORI, OP_LW, OP_SW});
    ext   = dp && (op != OP_ORI);
    rd    = dp && (op inside {OP_ADD, OP_SUB});
    dbs   = dp && (op == OP_LW);
    if (!dp)                                  aop = 3'b000;
    else if (op inside {OP_SUB, OP_BEQ, OP_BNE}) aop = 3'b001;
    else if (op == OP_ORI)                    aop = 3'b011;
    else                                      aop = 3'b000;
    return {st == S_IF, pcw, pcs, st == S_WB, rd, asb, ext,
            (st == S_MEM) && (op == OP_LW), (st == S_MEM) && (op == OP_SW), dbs, aop,
            st == S_HLT};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle_check(input string name, input logic [2:0] st, input logic [13:0] bits);
    check({name, "_state"}, 32'(State), 32'(st));
    check({name, "_ctrl"}, 32'(w_act), 32'(bits));
    check({name, "_cnt"}, 32'(InsCount), 32'(exp_cnt));
  endtask

  task automatic add(input logic [5:0] op, input logic z, input int len,
                     input logic [14:0] p);
    tbl[n_tbl].op   = op;
    tbl[n_tbl].zero = z;
    tbl[n_tbl].len  = len;
    tbl[n_tbl].path = p;
    n_tbl++;
  endtask

  // Called right after a falling edge; ends right after the falling edge following the last cycle.
  task automatic run_instr(input int idx);
    vec_t v;
    exp_t e;
    logic pcw;
    v = tbl[idx];
    for (int c = 0; c < v.len; c++) begin
      pcw   = (c == v.len - 1) && (v.op != OP_HALT);
      e.st  = v.path[c];
      e.bits = exp_ctrl(v.path[c], v.op, v.zero, pcw);
      e.pcw = pcw;
      sb.push_back(e);
    end
    for (int c = 0; c < v.len; c++) begin
      // After IF the opcode bus carries junk: decode must use the captured copy.
      Opcode = (c == 0) ? v.op : ~v.op;
      Zero   = v.zero;
      #1;
      e = sb.pop_front();
      cycle_check($sformatf("instr%0d_op%b_c%0d", idx, v.op, c), e.st, e.bits);
      if (e.pcw) exp_cnt++;
      @(negedge CLK);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Paths are listed last state first: {s4, s3, s2, s1, s0}.
    add(OP_ADD,  1'b0, 4, {S_IF, S_WB, S_EXE, S_ID, S_IF});
    add(OP_LW,   1'b0, 5, {S_WB, S_MEM, S_EXE, S_ID, S_IF});
    add(OP_SW,   1'b0, 4, {S_IF, S_MEM, S_EXE, S_ID, S_IF});
    add(OP_BEQ,  1'b1, 3, {S_IF, S_IF, S_EXE, S_ID, S_IF});
    add(OP_BEQ,  1'b0, 3, {S_IF, S_IF, S_EXE, S_ID, S_IF});
    add(OP_BNE,  1'b0, 3, {S_IF, S_IF, S_EXE, S_ID, S_IF});
    add(OP_BNE,  1'b1, 3, {S_IF, S_IF, S_EXE, S_ID, S_IF});
    add(OP_SUB,  1'b0, 4, {S_IF, S_WB, S_EXE, S_ID, S_IF});
    add(OP_ADDI, 1'b0, 4, {S_IF, S_WB, S_EXE, S_ID, S_IF});
    add(OP_ORI,  1'b0, 4, {S_IF, S_WB, S_EXE, S_ID, S_IF});
    add(OP_NOP,  1'b0, 2, {S_IF, S_IF, S_IF, S_ID, S_IF});
    add(OP_HALT, 1'b0, 2, {S_IF, S_IF, S_IF, S_ID, S_IF});

    Reset = 1'b0; Opcode = OP_ADD; Zero = 1'b0;
    Reset2 = 1'b0; Opcode2 = OP_SW; Zero2 = 1'b0;
    #1;
    cycle_check("reset_hold", S_IF, 14'd0);
    repeat (2) @(negedge CLK);
    cycle_check("reset_hold_clocked", S_IF, 14'd0);
    Reset = 1'b1;

    for (int i = 0; i < n_tbl; i++) run_instr(i);

    // HALT: stays put with Halt=1 and the counter frozen.
    for (int c = 0; c < 10; c++) begin
      Opcode = 6'($urandom);
      Zero   = 1'($urandom);
      #1;
      cycle_check($sformatf("hlt_c%0d", c), S_HLT, exp_ctrl(S_HLT, OP_HALT, 1'b0, 1'b0));
      @(negedge CLK);
    end

    Reset = 1'b0;
    #1;
    exp_cnt = '0;
    cycle_check("reset_from_hlt", S_IF, 14'd0);
    @(negedge CLK);
    Reset = 1'b1;
    run_instr(0);

    // ADDI interrupted by an asynchronous reset in the middle of EXE.
    Opcode = OP_ADDI; Zero = 1'b0;
    #1;
    cycle_check("addi_if", S_IF, exp_ctrl(S_IF, OP_ADDI, 1'b0, 1'b0));
    @(negedge CLK);
    Opcode = ~OP_ADDI;
    #1;
    cycle_check("addi_id", S_ID, exp_ctrl(S_ID, OP_ADDI, 1'b0, 1'b0));
    @(negedge CLK);
    #1;
    cycle_check("addi_exe", S_EXE, exp_ctrl(S_EXE, OP_ADDI, 1'b0, 1'b0));
    #2;
    Reset = 1'b0;
    #1;
    exp_cnt = '0;
    cycle_check("async_reset_mid_exe", S_IF, 14'd0);
    @(negedge CLK);
    cycle_check("async_reset_held", S_IF, 14'd0);
    Reset = 1'b1;
    run_instr(0);

    // COUNT_W=4 instance running back-to-back SW: 4 cycles each, wraps after 16.
    Reset2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      repeat (4) @(posedge CLK);
      #1;
      check($sformatf("w4_cnt_after_sw%0d", k), 32'(InsCount2), 32'(k % 16));
      check($sformatf("w4_state_after_sw%0d", k), 32'(State2), 32'(S_IF));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
